pipe_stage_buf: RTL
===================

# pipe_stage_buf

Parametrised valid/ready pipeline stage buffer for the fetch→decode boundary (and reusable at any later stage boundary). Holds instruction word, PC and an optional sideband field; a two-entry skid structure lets the upstream ready be fully registered without losing throughput. Synchronous flush squashes all held entries to a NOP bubble. Emptied or flushed slots present the canonical NOP (addi x0,x0,0) so downstream decode never sees stale instructions.

## Interface
Parameters:
- XLEN, 32, PC width
- ILEN, 32, instruction width
- SIDE_W, 1, sideband width (min 1; tie off if unused)
- NOP_INSTR, 32'h00000013, instruction presented when stage is empty
- CNT_W, 16, stall-counter width (used only with the configuration macro)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- flush  in  1  squash all held entries this cycle
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage can accept; registered, depends only on state
- in_instr  in  ILEN  instruction
- in_pc  in  XLEN  PC
- in_side  in  SIDE_W  sideband
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_instr  out  ILEN  instruction
- out_pc  out  XLEN  PC
- out_side  out  SIDE_W  sideband
- stall_cnt  out  CNT_W  upstream-stall cycle count (only with PIPE_STAGE_BUF_STALL_CNT_EN)

## Operation
- Storage: main register (drives out_*) and skid register.
- States: EMPTY (nothing held), BUSY (main valid), FULL (main + skid valid).
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state != FULL). out_valid = (state != EMPTY).
- EMPTY: in_fire → BUSY, main ← in.
- BUSY: in_fire & out_fire → BUSY, main ← in; in_fire & !out_fire → FULL, skid ← in; !in_fire & out_fire → EMPTY, main_instr ← NOP_INSTR, main_pc ← 0, main_side ← 0; else hold.
- FULL: out_fire → BUSY, main ← skid; else hold. No input accepted.
- Order strictly FIFO; no entry dropped or duplicated except by flush.
- flush: highest priority over all transitions; state ← EMPTY, main ← {NOP_INSTR, 0, 0}; skid contents discarded; an in_fire in the same cycle is dropped; out_fire in that cycle still counts as consumed downstream.
- Reset (rst=0 at clk edge): identical to flush plus stall_cnt ← 0.
- Reset values: out_valid 0, out_instr NOP_INSTR, out_pc 0, out_side 0, in_ready 1, stall_cnt 0.
- Held data stable while out_valid & !out_ready.

## Timing
- Latency: in_fire at edge N → out_valid/out_* updated after edge N (visible cycle N+1).
- Throughput: 1 entry/cycle sustained when out_ready=1.
- in_ready and out_valid are pure register outputs; no combinational path from out_ready or in_valid to any output.
- After downstream stall of one cycle with continuous input: stage enters FULL, in_ready drops the next cycle; resumes one cycle after out_fire.
- flush takes effect at the edge it is sampled; out_valid=0 the following cycle.

## Configuration
- PIPE_STAGE_BUF_STALL_CNT_EN defined: stall_cnt port present; increments by 1 each cycle with in_valid=1 & in_ready=0, saturates at all-ones, cleared only by reset (not by flush).
- Not defined: stall_cnt port and counter absent; all other behaviour identical.

## Test plan
- Reset: hold rst=0 two cycles with random inputs → out_valid=0, out_instr=32'h00000013, out_pc=0, in_ready=1.
- Streaming: out_ready=1, push instr 0x00A00093/0x00100113/0x002081B3 at PCs 0x0/0x4/0x8 back-to-back → same sequence on out_* one cycle later, in_ready stays 1.
- Backpressure: out_ready=0 for 3 cycles during streaming → state FULL, in_ready=0 one cycle after second push, no loss; release → entries emerge in order PC 0x0,0x4,0x8.
- Flush in FULL with simultaneous in_valid: next cycle out_valid=0, out_instr=0x00000013, in_ready=1; flushed and same-cycle inputs never appear.
- Empty drain: single push then out_fire → out_valid=0 and out_instr returns to 0x00000013, out_pc=0.
- With PIPE_STAGE_BUF_STALL_CNT_EN, CNT_W=4: hold FULL with in_valid=1 for 20 cycles → stall_cnt saturates at 15; flush leaves 15; reset clears to 0.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Valid/ready pipeline stage buffer for the fetch->decode boundary (usable
//   at any stage boundary). A main register drives the outputs and a skid
//   register catches the one entry that can arrive while the main register
//   is stalled. This lets in_ready be a pure register output with no loss
//   of throughput. An empty or flushed stage presents NOP_INSTR with PC and
//   sideband zero, so decode never sees a stale instruction.
//
//   Optional feature macro: PIPE_STAGE_BUF_STALL_CNT_EN
//     When defined, a saturating upstream-stall counter is added and driven
//     on stall_cnt. The counter is cleared by reset only, not by flush.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-low
//   flush      in   squash all held entries this cycle
//   in_valid   in   upstream has an entry
//   in_ready   out  stage can accept (registered)
//   in_instr   in   [ILEN]   instruction
//   in_pc      in   [XLEN]   PC
//   in_side    in   [SIDE_W] sideband
//   out_valid  out  entry presented downstream (registered)
//   out_ready  in   downstream accepts
//   out_instr  out  [ILEN]   instruction
//   out_pc     out  [XLEN]   PC
//   out_side   out  [SIDE_W] sideband
//   stall_cnt  out  [CNT_W]  cycles with in_valid & !in_ready (macro only)
module pipe_stage_buf #(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter int              SIDE_W    = 1,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013,
    parameter int              CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ILEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ILEN-1:0]   out_instr,
    output logic [XLEN-1:0]   out_pc,
    output logic [SIDE_W-1:0] out_side
`ifdef PIPE_STAGE_BUF_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              w_in_ready_nxt;
    logic              w_out_valid_nxt;

    logic [ILEN-1:0]   r_main_instr;
    logic [XLEN-1:0]   r_main_pc;
    logic [SIDE_W-1:0] r_main_side;
    logic [ILEN-1:0]   r_skid_instr;
    logic [XLEN-1:0]   r_skid_pc;
    logic [SIDE_W-1:0] r_skid_side;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_ld_in;
    logic              w_main_ld_skid;
    logic              w_main_clr;
    logic              w_skid_ld;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // ---- state register: also registers the handshake outputs ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // ---- next-state logic: flush overrides every transition ----
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_in_fire) w_state_nxt = S_BUSY;
                S_BUSY: begin
                    if (w_in_fire && !w_out_fire)      w_state_nxt = S_FULL;
                    else if (!w_in_fire && w_out_fire) w_state_nxt = S_EMPTY;
                end
                S_FULL:  if (w_out_fire) w_state_nxt = S_BUSY;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // ---- output / datapath-control decode ----
    // in_ready and out_valid are decoded from the next state and then
    // registered, so neither has a combinational path from any input.
    always_comb begin
        w_in_ready_nxt  = (w_state_nxt != S_FULL);
        w_out_valid_nxt = (w_state_nxt != S_EMPTY);
        w_main_ld_in    = 1'b0;
        w_main_ld_skid  = 1'b0;
        w_main_clr      = 1'b0;
        w_skid_ld       = 1'b0;
        if (flush) begin
            w_main_clr = 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: w_main_ld_in = w_in_fire;
                S_BUSY: begin
                    if (w_in_fire && w_out_fire)  w_main_ld_in = 1'b1;
                    else if (w_in_fire)           w_skid_ld    = 1'b1;
                    else if (w_out_fire)          w_main_clr   = 1'b1;
                end
                S_FULL:  w_main_ld_skid = w_out_fire;
                default: w_main_clr = 1'b1;
            endcase
        end
    end

    // ---- main register: reset/flush/drain present the NOP bubble ----
    always_ff @(posedge clk) begin
        if (!rst || w_main_clr) begin
            r_main_instr <= NOP_INSTR;
            r_main_pc    <= '0;
            r_main_side  <= '0;
        end else if (w_main_ld_in) begin
            r_main_instr <= in_instr;
            r_main_pc    <= in_pc;
            r_main_side  <= in_side;
        end else if (w_main_ld_skid) begin
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
            r_main_side  <= r_skid_side;
        end
    end

    // ---- skid register: contents only meaningful in S_FULL ----
    always_ff @(posedge clk) begin
        if (w_skid_ld) begin
            r_skid_instr <= in_instr;
            r_skid_pc    <= in_pc;
            r_skid_side  <= in_side;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_instr = r_main_instr;
    assign out_pc    = r_main_pc;
    assign out_side  = r_main_side;

`ifdef PIPE_STAGE_BUF_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // ---- stall counter: flush deliberately does not clear it ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (in_valid && !r_in_ready) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
